// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-master data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        FREE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_e;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    // Anything that is not an explicit byte or half mask is a full word.
    function automatic logic [3:0] norm_mask(input logic [3:0] mask);
        if (mask == MASK_B) return MASK_B;
        if (mask == MASK_H) return MASK_H;
        return MASK_W;
    endfunction

endpackage

// File: rtl/dmem_arb_port.sv
// Per-master response registers: one-cycle ack pulse and read data held until the next read.
module dmem_arb_port #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_gnt,
    input  logic              i_we,
    input  logic [DATA_W-1:0] i_rdata,
    output logic              o_ack,
    output logic [DATA_W-1:0] o_rdata
);

    logic              r_ack;
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ack   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ack <= i_gnt;
            if (i_gnt && !i_we) begin
                r_rdata <= i_rdata;
            end
        end
    end

    assign o_ack   = r_ack;
    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter with bounded locking that shares one data memory between two masters.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned MAX_LOCK = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [3:0]        m0_mask,
    input  logic              m0_lock,
    output logic              m0_gnt,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [3:0]        m1_mask,
    input  logic              m1_lock,
    output logic              m1_gnt,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_ce,
    output logic              mem_we,
    output logic              mem_memRr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wtData,
    output logic [3:0]        mem_w_mask,
    output logic [3:0]        mem_r_mask,
    input  logic [DATA_W-1:0] mem_rdData
);

    localparam int unsigned CNT_W = $clog2(MAX_LOCK);

    arb_state_e       r_state, w_state_nxt;
    logic             r_ptr, w_ptr_nxt;
    logic [CNT_W-1:0] r_lock_cnt, w_lock_cnt_nxt;
    logic [1:0]       w_gnt;
    logic             w_lock_max;

    assign w_lock_max = (r_lock_cnt == CNT_W'(MAX_LOCK - 1));

    // Grants are gated by reset so nothing reaches the memory while rst_n is low.
    always_comb begin
        w_gnt = 2'b00;
        if (rst_n) begin
            case (r_state)
                FREE: begin
                    if (m0_req && m1_req) w_gnt = r_ptr ? 2'b10 : 2'b01;
                    else                  w_gnt = {m1_req, m0_req};
                end
                LOCK0:   w_gnt = {1'b0, m0_req};
                LOCK1:   w_gnt = {m1_req, 1'b0};
                default: w_gnt = 2'b00;
            endcase
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_lock_cnt_nxt = r_lock_cnt;
        case (r_state)
            FREE: begin
                if (w_gnt[0]) begin
                    w_ptr_nxt = 1'b1;
                    if (m0_lock) begin
                        w_state_nxt    = LOCK0;
                        w_lock_cnt_nxt = '0;
                    end
                end else if (w_gnt[1]) begin
                    w_ptr_nxt = 1'b0;
                    if (m1_lock) begin
                        w_state_nxt    = LOCK1;
                        w_lock_cnt_nxt = '0;
                    end
                end
            end
            LOCK0: begin
                if (!m0_lock || w_lock_max) begin
                    w_state_nxt    = FREE;
                    w_ptr_nxt      = 1'b1;
                    w_lock_cnt_nxt = '0;
                end else begin
                    w_lock_cnt_nxt = r_lock_cnt + CNT_W'(1);
                end
            end
            LOCK1: begin
                if (!m1_lock || w_lock_max) begin
                    w_state_nxt    = FREE;
                    w_ptr_nxt      = 1'b0;
                    w_lock_cnt_nxt = '0;
                end else begin
                    w_lock_cnt_nxt = r_lock_cnt + CNT_W'(1);
                end
            end
            default: w_state_nxt = FREE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= FREE;
            r_ptr      <= 1'b0;
            r_lock_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
        end
    end

    always_comb begin
        mem_ce     = 1'b0;
        mem_we     = 1'b0;
        mem_memRr  = 1'b0;
        mem_addr   = '0;
        mem_wtData = '0;
        mem_w_mask = '0;
        mem_r_mask = '0;
        if (w_gnt[0]) begin
            mem_ce     = 1'b1;
            mem_we     = m0_we;
            mem_memRr  = ~m0_we;
            mem_addr   = m0_addr;
            mem_wtData = m0_wdata;
            mem_w_mask = norm_mask(m0_mask);
            mem_r_mask = norm_mask(m0_mask);
        end else if (w_gnt[1]) begin
            mem_ce     = 1'b1;
            mem_we     = m1_we;
            mem_memRr  = ~m1_we;
            mem_addr   = m1_addr;
            mem_wtData = m1_wdata;
            mem_w_mask = norm_mask(m1_mask);
            mem_r_mask = norm_mask(m1_mask);
        end
    end

    assign m0_gnt = w_gnt[0];
    assign m1_gnt = w_gnt[1];

    dmem_arb_port #(
        .DATA_W (DATA_W)
    ) u_port0 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_gnt   (w_gnt[0]),
        .i_we    (m0_we),
        .i_rdata (mem_rdData),
        .o_ack   (m0_ack),
        .o_rdata (m0_rdata)
    );

    dmem_arb_port #(
        .DATA_W (DATA_W)
    ) u_port1 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_gnt   (w_gnt[1]),
        .i_we    (m1_we),
        .i_rdata (mem_rdData),
        .o_ack   (m1_ack),
        .o_rdata (m1_rdata)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus a randomized run checked against
// a transaction-level model of ownership, round-robin pointer and memory contents.
module tb_dmem_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned ML = 4;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    req   = 2'b00;
    logic [1:0]    we    = 2'b00;
    logic [1:0]    lock  = 2'b00;
    logic [AW-1:0] addr  [2];
    logic [DW-1:0] wdata [2];
    logic [3:0]    mask  [2];

    logic          m0_gnt, m1_gnt, m0_ack, m1_ack;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          mem_ce, mem_we, mem_memRr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wtData, mem_rdData;
    logic [3:0]    mem_w_mask, mem_r_mask;

    logic [31:0] mem     [1024];
    logic [31:0] ref_mem [1024];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: owner -1 = nobody holds a lock.
    int          owner;
    int          ptr;
    int          held;
    bit          g       [2];
    bit          exp_ack [2];
    logic [31:0] exp_rd  [2];

    dmem_arbiter #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .MAX_LOCK (ML)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .m0_req     (req[0]),
        .m0_we      (we[0]),
        .m0_addr    (addr[0]),
        .m0_wdata   (wdata[0]),
        .m0_mask    (mask[0]),
        .m0_lock    (lock[0]),
        .m0_gnt     (m0_gnt),
        .m0_ack     (m0_ack),
        .m0_rdata   (m0_rdata),
        .m1_req     (req[1]),
        .m1_we      (we[1]),
        .m1_addr    (addr[1]),
        .m1_wdata   (wdata[1]),
        .m1_mask    (mask[1]),
        .m1_lock    (lock[1]),
        .m1_gnt     (m1_gnt),
        .m1_ack     (m1_ack),
        .m1_rdata   (m1_rdata),
        .mem_ce     (mem_ce),
        .mem_we     (mem_we),
        .mem_memRr  (mem_memRr),
        .mem_addr   (mem_addr),
        .mem_wtData (mem_wtData),
        .mem_w_mask (mem_w_mask),
        .mem_r_mask (mem_r_mask),
        .mem_rdData (mem_rdData)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // Data memory seen by the DUT.
    assign mem_rdData = mem[mem_addr[11:2]];
    always @(posedge clk) begin
        if (mem_ce && mem_we) mem[mem_addr[11:2]] <= merge(mem[mem_addr[11:2]], mem_wtData, mem_w_mask);
    end

    task automatic model_reset();
        owner = -1; ptr = 0; held = 0;
        exp_ack[0] = 0; exp_ack[1] = 0;
        exp_rd[0] = '0; exp_rd[1] = '0;
    endtask

    task automatic model_grant();
        g[0] = 0; g[1] = 0;
        if (!rst_n) return;
        if (owner >= 0)          g[owner] = req[owner];
        else if (req == 2'b11)   g[ptr] = 1;
        else begin g[0] = req[0]; g[1] = req[1]; end
    endtask

    task automatic model_commit();
        int w;
        for (int k = 0; k < 2; k++) begin
            exp_ack[k] = g[k];
            if (g[k]) begin
                if (we[k]) ref_mem[addr[k][11:2]] = merge(ref_mem[addr[k][11:2]], wdata[k], mask[k]);
                else       exp_rd[k] = ref_mem[addr[k][11:2]];
            end
        end
        w = g[1] ? 1 : 0;
        if (owner < 0) begin
            if (g[0] || g[1]) begin
                ptr = 1 - w;
                if (lock[w]) begin owner = w; held = 0; end
            end
        end else if (!lock[owner] || held == int'(ML) - 1) begin
            ptr = 1 - owner; owner = -1;
        end else begin
            held++;
        end
    endtask

    // Inputs are driven 1 time unit after a rising edge; outputs are sampled at the falling edge.
    task automatic to_negedge();
        #4;
        model_grant();
    endtask

    task automatic to_next();
        @(posedge clk);
        if (rst_n) model_commit(); else model_reset();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 2'b11; we = 2'b00; lock = 2'b00;
        addr[0] = 32'h40; addr[1] = 32'h44;
        for (int c = 0; c < 2; c++) begin
            to_negedge();
            n_checks++;
            if ({m1_gnt, m0_gnt} !== 2'b00) begin
                n_fail++; $display("FAIL reset_gnt got %b want 00", {m1_gnt, m0_gnt});
            end
            n_checks++;
            if ({mem_ce, mem_we, mem_memRr, mem_addr, mem_wtData, mem_w_mask, mem_r_mask} !== '0) begin
                n_fail++; $display("FAIL reset_mem ce=%b we=%b addr=%h", mem_ce, mem_we, mem_addr);
            end
            n_checks++;
            if ({m1_ack, m0_ack} !== 2'b00 || m0_rdata !== '0 || m1_rdata !== '0) begin
                n_fail++;
                $display("FAIL reset_resp ack=%b rd0=%h rd1=%h want 0", {m1_ack, m0_ack}, m0_rdata, m1_rdata);
            end
            to_next();
        end
        rst_n = 1'b1;
        to_negedge();
        n_checks++;
        if ({m1_gnt, m0_gnt} !== 2'b01) begin
            n_fail++; $display("FAIL reset_first_grant got %b want 01", {m1_gnt, m0_gnt});
        end
        to_next();
        req = 2'b00;
        to_negedge();
        n_checks++;
        if (m0_ack !== 1'b1 || m0_rdata !== exp_rd[0]) begin
            n_fail++; $display("FAIL reset_first_ack ack=%b rd=%h want 1 %h", m0_ack, m0_rdata, exp_rd[0]);
        end
        to_next();
    endtask

    task automatic test_read_data();
        req = 2'b10; we = 2'b00; addr[1] = 32'h0;
        to_negedge();
        n_checks++;
        if (m1_gnt !== 1'b1) begin n_fail++; $display("FAIL read_gnt got %b want 1", m1_gnt); end
        to_next();
        req = 2'b00;
        to_negedge();
        n_checks++;
        if (m1_ack !== 1'b1 || m1_rdata !== 32'h0000_0138) begin
            n_fail++; $display("FAIL read_data ack=%b rd=%h want 1 00000138", m1_ack, m1_rdata);
        end
        to_next();
        req = 2'b10; we = 2'b10; addr[1] = 32'h30; wdata[1] = 32'h1234_5678;
        to_negedge();
        to_next();
        req = 2'b00;
        to_negedge();
        n_checks++;
        if (m1_ack !== 1'b1 || m1_rdata !== 32'h0000_0138) begin
            n_fail++; $display("FAIL read_hold_after_write ack=%b rd=%h want 1 00000138", m1_ack, m1_rdata);
        end
        to_next();
    endtask

    task automatic test_contention();
        req = 2'b11; we = 2'b11; lock = 2'b00;
        addr[0] = 32'h10; wdata[0] = 32'hAAAA_0001;
        addr[1] = 32'h20; wdata[1] = 32'hBBBB_0002;
        for (int c = 0; c < 6; c++) begin
            to_negedge();
            n_checks++;
            if ({m1_gnt, m0_gnt} !== {g[1], g[0]} || {m1_ack, m0_ack} !== {exp_ack[1], exp_ack[0]}) begin
                n_fail++;
                $display("FAIL contention_cycle%0d gnt=%b ack=%b want gnt=%b ack=%b", c,
                         {m1_gnt, m0_gnt}, {m1_ack, m0_ack}, {g[1], g[0]}, {exp_ack[1], exp_ack[0]});
            end
            to_next();
        end
        req = 2'b00;
        to_negedge();
        n_checks++;
        if ({m1_ack, m0_ack} !== {exp_ack[1], exp_ack[0]}) begin
            n_fail++; $display("FAIL contention_last_ack got %b want %b", {m1_ack, m0_ack},
                               {exp_ack[1], exp_ack[0]});
        end
        to_next();
        for (int k = 0; k < 2; k++) begin
            req = (k == 0) ? 2'b01 : 2'b10; we = 2'b00;
            to_negedge();
            to_next();
            req = 2'b00;
            to_negedge();
            n_checks++;
            if (k == 0 && (m0_ack !== 1'b1 || m0_rdata !== 32'hAAAA_0001)) begin
                n_fail++; $display("FAIL readback_m0 ack=%b rd=%h want 1 aaaa0001", m0_ack, m0_rdata);
            end else if (k == 1 && (m1_ack !== 1'b1 || m1_rdata !== 32'hBBBB_0002)) begin
                n_fail++; $display("FAIL readback_m1 ack=%b rd=%h want 1 bbbb0002", m1_ack, m1_rdata);
            end
            to_next();
        end
    endtask

    task automatic test_lock();
        req = 2'b01; we = 2'b00; lock = 2'b01; addr[0] = 32'h4; addr[1] = 32'h8;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) req = 2'b11;
            if (c == 3) lock = 2'b00;
            to_negedge();
            n_checks++;
            if ({m1_gnt, m0_gnt} !== 2'b01) begin
                n_fail++; $display("FAIL lock_hold_cycle%0d gnt=%b want 01", c, {m1_gnt, m0_gnt});
            end
            to_next();
        end
        to_negedge();
        n_checks++;
        if ({m1_gnt, m0_gnt} !== 2'b10) begin
            n_fail++; $display("FAIL lock_release gnt=%b want 10", {m1_gnt, m0_gnt});
        end
        to_next();
        req = 2'b00;
        to_negedge();
        to_next();
    endtask

    task automatic test_forced_release();
        int found;
        found = -1;
        req = 2'b11; we = 2'b00; lock = 2'b01;
        for (int c = 0; c < 20 && found < 0; c++) begin
            to_negedge();
            if (c == 0) begin
                n_checks++;
                if (m0_gnt !== 1'b1) begin n_fail++; $display("FAIL forced_first got %b want 1", m0_gnt); end
            end
            if (m1_gnt === 1'b1) found = c;
            to_next();
        end
        n_checks++;
        if (found != int'(ML) + 1) begin
            n_fail++; $display("FAIL forced_release m1 granted after %0d cycles want %0d", found, ML + 1);
        end
        req = 2'b00; lock = 2'b00;
        to_negedge();
        to_next();
    endtask

    task automatic test_reset_mid_op();
        req = 2'b10; we = 2'b10; lock = 2'b10; addr[1] = 32'h30; wdata[1] = 32'h1111_2222;
        to_negedge();
        n_checks++;
        if (m1_gnt !== 1'b1) begin n_fail++; $display("FAIL midrst_lock_gnt got %b want 1", m1_gnt); end
        to_next();
        addr[1] = 32'h10; wdata[1] = 32'hDEAD_BEEF;
        #2 rst_n = 1'b0;
        model_reset();
        #2 model_grant();
        n_checks++;
        if ({m1_gnt, m0_gnt, mem_ce, mem_we, m1_ack, m0_ack} !== 6'b0) begin
            n_fail++; $display("FAIL midrst_outputs gnt=%b ce=%b we=%b ack=%b want all 0",
                               {m1_gnt, m0_gnt}, mem_ce, mem_we, {m1_ack, m0_ack});
        end
        to_next();
        n_checks++;
        if (mem[4] !== 32'hAAAA_0001 || {m1_ack, m0_ack} !== 2'b00) begin
            n_fail++; $display("FAIL midrst_no_commit mem=%h ack=%b want aaaa0001 00", mem[4], {m1_ack, m0_ack});
        end
        req = 2'b11; we = 2'b00; lock = 2'b10;
        rst_n = 1'b1;
        to_negedge();
        n_checks++;
        if ({m1_gnt, m0_gnt} !== 2'b01) begin
            n_fail++; $display("FAIL midrst_state gnt=%b want 01", {m1_gnt, m0_gnt});
        end
        to_next();
        req = 2'b00; lock = 2'b00;
        to_negedge();
        to_next();
    endtask

    task automatic test_random();
        logic [31:0] e_addr, e_wd;
        logic [3:0]  e_mask;
        logic        e_ce, e_we, e_rr;
        for (int c = 0; c < 300; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (!(req[k] && !g[k])) begin
                    req[k]   = ($urandom_range(0, 9) < 7);
                    we[k]    = 1'($urandom_range(0, 1));
                    lock[k]  = ($urandom_range(0, 3) == 0);
                    addr[k]  = 32'($urandom_range(0, 15)) << 2;
                    wdata[k] = $urandom();
                    case ($urandom_range(0, 2))
                        0:       mask[k] = 4'b0001;
                        1:       mask[k] = 4'b0011;
                        default: mask[k] = 4'b1111;
                    endcase
                end
            end
            to_negedge();
            e_ce = 0; e_we = 0; e_rr = 0; e_addr = '0; e_wd = '0; e_mask = '0;
            for (int k = 0; k < 2; k++) begin
                if (g[k]) begin
                    e_ce = 1; e_we = we[k]; e_rr = !we[k];
                    e_addr = addr[k]; e_wd = wdata[k]; e_mask = mask[k];
                end
            end
            n_checks++;
            if ({m1_gnt, m0_gnt, mem_ce, mem_we, mem_memRr} !== {g[1], g[0], e_ce, e_we, e_rr}) begin
                n_fail++; $display("FAIL rand%0d_ctrl got %b want %b", c,
                                   {m1_gnt, m0_gnt, mem_ce, mem_we, mem_memRr}, {g[1], g[0], e_ce, e_we, e_rr});
            end
            n_checks++;
            if ({mem_addr, mem_wtData, mem_w_mask, mem_r_mask} !== {e_addr, e_wd, e_mask, e_mask}) begin
                n_fail++; $display("FAIL rand%0d_bus addr=%h wd=%h wm=%b rm=%b want %h %h %b", c,
                                   mem_addr, mem_wtData, mem_w_mask, mem_r_mask, e_addr, e_wd, e_mask);
            end
            n_checks++;
            if ({m1_ack, m0_ack, m1_rdata, m0_rdata} !== {exp_ack[1], exp_ack[0], exp_rd[1], exp_rd[0]}) begin
                n_fail++; $display("FAIL rand%0d_resp ack=%b rd1=%h rd0=%h want %b %h %h", c,
                                   {m1_ack, m0_ack}, m1_rdata, m0_rdata, {exp_ack[1], exp_ack[0]},
                                   exp_rd[1], exp_rd[0]);
            end
            to_next();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = 32'h0000_0138 + 32'(i) * 32'h0101_0101;
            ref_mem[i] = 32'h0000_0138 + 32'(i) * 32'h0101_0101;
        end
        for (int k = 0; k < 2; k++) begin
            addr[k] = '0; wdata[k] = '0; mask[k] = 4'b1111;
        end
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_read_data();
        test_contention();
        test_lock();
        test_forced_release();
        test_reset_mid_op();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-master arbiter that shares the single-port data memory (1024×32, combinational read, synchronous write, byte/half/word masks) between the CPU load/store path (master 0) and a second requester such as a loader/debug/DMA engine (master 1). It sits directly in front of the data memory and drives its chip-enable, write-enable, read-enable, address, write data and masks. It returns registered read data and an acknowledge to each master. Round-robin fairness and bounded lock (atomic sequence) support are built in.

## Interface
- `DATA_W`, default 32: data width; must match the memory word.
- `ADDR_W`, default 32: byte address width; the memory uses `addr[11:2]`.
- `MAX_LOCK`, default 16: maximum consecutive cycles one master may hold a lock; legal range ≥2.
- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `mN_req` in 1 (N=0,1): access request; held with its command until granted.
- `mN_we` in 1: 1 = write, 0 = read.
- `mN_addr` in ADDR_W: byte address.
- `mN_wdata` in DATA_W: write data.
- `mN_mask` in 4: 4'b0001 byte, 4'b0011 half, other = word; applied to both read and write masks.
- `mN_lock` in 1: request exclusive ownership starting with this grant.
- `mN_gnt` out 1: combinational; access performed this cycle.
- `mN_ack` out 1: registered; one-cycle pulse the cycle after the grant.
- `mN_rdata` out DATA_W: registered read data; valid with `mN_ack` for reads and held until that master's next read ack.
- `mem_ce`, `mem_we`, `mem_memRr` out 1: memory enables.
- `mem_addr` out ADDR_W; `mem_wtData` out DATA_W; `mem_w_mask`, `mem_r_mask` out 4.
- `mem_rdData` in DATA_W: memory combinational read data.

## Operation
- The arbiter has three states: FREE, LOCK0 and LOCK1. It has a 1-bit priority pointer `ptr` and a lock counter `lock_cnt`.
- **FREE grants:**
  - Exactly one master is granted if any `req` is high.
  - If both request, master `ptr` wins.
  - After any grant, `ptr` moves to the other master.
- **LOCKx grants:** only master x may be granted, when `mx_req`=1. The other master is never granted, even if x is idle.
- **Transitions:**
  - FREE→LOCKx: at the edge of a grant to x with `mx_lock`=1. `lock_cnt` is set to 0.
  - LOCKx→FREE: at the first edge where `mx_lock`=0, or where `lock_cnt`==MAX_LOCK-1 (forced release). On exit, `ptr` is set to the other master.
  - Otherwise `lock_cnt` increments every cycle in LOCKx, granted or not.
- **Memory drive:**
  - When granted: `mem_ce`=1, `mem_we`=`we`, `mem_memRr`=~`we`, and addr/data/masks are passed through from the granted master.
  - With no grant, every memory output is 0.
- **Ack and read data:** on the edge ending a grant cycle, `mN_ack`←1. For a read, `mN_rdata`←`mem_rdData`; writes leave `mN_rdata` unchanged.
- **Reset (asynchronous, any time):**
  - Reset values: state=FREE, `ptr`=0, `lock_cnt`=0, both `ack`=0, both `rdata`=0.
  - While `rst_n`=0, both `gnt`=0 and all memory outputs are 0, so no write commits.

## Timing
- Grant is combinational in the request cycle. The write commits at the end of that cycle.
- Read and write latency: `ack` is asserted one cycle after the grant, with data.
- Back-to-back: a master holding `req` can be granted every cycle in LOCKx, or every other cycle under contention in FREE.
- Worst-case wait for an unlocked requester is MAX_LOCK+1 cycles.
- A master must not change its command while `req`=1 and `gnt`=0.

## Structure
- Package `dmem_arb_pkg` holds:
  - the state enum FREE/LOCK0/LOCK1;
  - mask constants MASK_B=4'b0001, MASK_H=4'b0011, MASK_W=4'b1111.
- Sub-module `dmem_arb_port`, instantiated twice, holds the per-master `ack`/`rdata` capture registers. The arbitration FSM and output multiplexing stay in the top level.

## Test plan
1. **Reset:** hold reset with both req=1 → gnt=00, mem_ce=0, ack=0, rdata=0. Release → cycle 1 grants m0 (ptr=0).
2. **Contention:** both write continuously (m0: 0x10←0xAAAA0001, m1: 0x20←0xBBBB0002) → grants alternate m0,m1,m0…; each ack arrives exactly 1 cycle after its grant; readback gives the written words.
3. **Read data:** m1 reads 0x0 after reset → m1_ack=1 next cycle with m1_rdata=0x00000138. A following m1 write does not change m1_rdata.
4. **Lock:** m0 locks for 3 cycles while m1 requests → m1_gnt=0 throughout. m0 drops lock → FREE, and m1 is granted on the next cycle.
5. **Forced release:** m0 keeps lock=1 with MAX_LOCK=4 → m1 is granted exactly 5 cycles after m0's first grant.
6. **Reset mid-operation:** assert reset during an m1 locked write to 0x10 → no commit (0x10 unchanged), ack=0, state FREE, ptr=0.
